// File: rtl/tick_sched.sv
// Periodic event scheduler: a shared prescaler drives four programmable-period channels
// whose fires are queued as pending bits and presented one at a time, round-robin.
module tick_sched #(
    parameter int PRESCALE = 100_000,
    parameter int NCH      = 4,
    parameter int PW       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_ch,
    input  logic           cfg_en,
    input  logic [PW-1:0]  cfg_period,
    output logic           evt_valid,
    output logic [1:0]     evt_id,
    input  logic           evt_ready,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr
);

    localparam int             PSW     = $clog2(PRESCALE);
    localparam logic [PSW-1:0] PRE_MAX = PSW'(PRESCALE - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    logic [PSW-1:0]         presc_q, presc_d;
    logic                   base_tick_s;
    logic [NCH-1:0]         en_q, en_d;
    logic [NCH-1:0][PW-1:0] per_q, per_d;
    logic [NCH-1:0][PW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]         fire_s, dis_s, acc_hit_s, cand_s;
    logic [NCH-1:0]         pending_q, pending_d;
    logic [NCH-1:0]         ovf_q, ovf_d;
    state_t                 state_q;
    logic [1:0]             evt_id_q, last_grant_q;
    logic                   present_s, acc_s, sel_found_s;
    logic [1:0]             sel_s, idx_s;

    assign base_tick_s = (presc_q == PRE_MAX);
    assign presc_d     = base_tick_s ? {PSW{1'b0}} : presc_q + PSW'(1);
    assign present_s   = (state_q == PRESENT);
    assign acc_s       = present_s && evt_ready;

    // Channel configuration and period counting; a write overrides the tick on its channel
    always_comb begin
        en_d      = en_q;
        per_d     = per_q;
        cnt_d     = cnt_q;
        fire_s    = {NCH{1'b0}};
        dis_s     = {NCH{1'b0}};
        acc_hit_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            acc_hit_s[i] = acc_s && (evt_id_q == 2'(i));
            if (cfg_we && (cfg_ch == 2'(i))) begin
                en_d[i]  = cfg_en;
                per_d[i] = cfg_period;
                cnt_d[i] = {PW{1'b0}};
                dis_s[i] = !cfg_en && !(present_s && (evt_id_q == 2'(i)));
            end else if (base_tick_s && en_q[i] && (per_q[i] != {PW{1'b0}})) begin
                if (cnt_q[i] == per_q[i] - PW'(1)) begin
                    cnt_d[i]  = {PW{1'b0}};
                    fire_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + PW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Pending/overrun bookkeeping; a fire on the channel being accepted re-arms without overrun
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            if (fire_s[i]) begin
                pending_d[i] = 1'b1;
            end else if (acc_hit_s[i] || dis_s[i]) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
            if (fire_s[i] && pending_q[i] && !acc_hit_s[i]) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clr) begin
                ovf_d[i] = 1'b0;
            end else begin
                ovf_d[i] = ovf_q[i];
            end
        end
    end

    // Round-robin pick starting after the last granted channel
    always_comb begin
        cand_s      = pending_q & ~dis_s;
        sel_found_s = 1'b0;
        sel_s       = 2'd0;
        idx_s       = 2'd0;
        for (int k = 1; k <= NCH; k++) begin
            idx_s = last_grant_q + 2'(k);
            if (!sel_found_s && cand_s[idx_s]) begin
                sel_found_s = 1'b1;
                sel_s       = idx_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Prescaler, channel state, pending and overrun registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= {PSW{1'b0}};
            en_q      <= {NCH{1'b0}};
            per_q     <= '0;
            cnt_q     <= '0;
            pending_q <= {NCH{1'b0}};
            ovf_q     <= {NCH{1'b0}};
        end else begin
            presc_q   <= presc_d;
            en_q      <= en_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Output presentation FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            evt_id_q     <= 2'd0;
            last_grant_q <= 2'(NCH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found_s) begin
                        evt_id_q <= sel_s;
                        state_q  <= PRESENT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        last_grant_q <= evt_id_q;
                        state_q      <= IDLE;
                    end else begin
                        state_q <= PRESENT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign evt_valid = (state_q == PRESENT);
    assign evt_id    = evt_id_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched with PRESCALE=4 (base tick every 4 clk).
module tb_tick_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic        cfg_en;
    logic [15:0] cfg_period;
    logic        evt_valid;
    logic [1:0]  evt_id;
    logic        evt_ready;
    logic [3:0]  ovf;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    tick_sched #(.PRESCALE(4), .NCH(4), .PW(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_period(cfg_period), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic wr(input logic [1:0] ch, input logic en, input logic [15:0] p);
        cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_period = p;
        tick();
        cfg_we = 1'b0;
    endtask

    // After this, edge number 1 is the first edge out of reset; base ticks land on edges 4, 8, 12...
    task automatic restart();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ecnt  = 0;
    endtask

    initial begin
        int ng;
        logic [1:0] gexp;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_en = 1'b0;
        cfg_period = 16'd0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // ch0 P=3: fires on edges 12 and 24, presented after edges 13 and 25
        restart();
        evt_ready = 1'b1;
        wr(2'd0, 1'b1, 16'd3);
        while (ecnt < 26) begin
            tick();
            chk("p3_valid", 32'(evt_valid), 32'((ecnt == 13) || (ecnt == 25)));
            if (evt_valid) chk("p3_id", 32'(evt_id), 32'd0);
        end

        // All channels P=1: grants rotate 0,1,2,3; accepts cannot keep up so overruns appear
        restart();
        evt_ready = 1'b1;
        wr(2'd0, 1'b1, 16'd1);
        wr(2'd1, 1'b1, 16'd1);
        wr(2'd2, 1'b1, 16'd1);
        wr(2'd3, 1'b1, 16'd1);
        ng = 0;
        gexp = 2'd0;
        for (int c = 0; c < 100 && ng < 8; c++) begin
            tick();
            if (evt_valid) begin
                chk("rr_grant", 32'(evt_id), 32'(gexp));
                gexp = gexp + 2'd1;
                ng++;
            end
        end
        chk("rr_count", 32'(ng), 32'd8);
        chk("rr_ovf", 32'(ovf), 32'hF);

        // ch1 held unaccepted across three base ticks: stable id, overrun, one delivery
        restart();
        evt_ready = 1'b0;
        wr(2'd1, 1'b1, 16'd1);
        while (ecnt < 5) tick();
        chk("hold_valid", 32'(evt_valid), 32'd1);
        chk("hold_id", 32'(evt_id), 32'd1);
        while (ecnt < 13) begin
            tick();
            chk("hold_stable", 32'({evt_valid, evt_id}), 32'h5);
        end
        chk("hold_ovf", 32'(ovf), 32'h2);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("hold_done", 32'(evt_valid), 32'd0);
        tick();
        chk("hold_single", 32'(evt_valid), 32'd0);

        // Rewrite of ch2 on a base-tick edge with cnt==P-1 suppresses that fire
        restart();
        evt_ready = 1'b1;
        wr(2'd2, 1'b1, 16'd2);
        while (ecnt < 7) tick();
        wr(2'd2, 1'b1, 16'd2);
        while (ecnt < 16) begin
            tick();
            chk("wrpri_quiet", 32'(evt_valid), 32'd0);
        end
        tick();
        chk("wrpri_valid", 32'(evt_valid), 32'd1);
        chk("wrpri_id", 32'(evt_id), 32'd2);

        // ovf_clr colliding with a fresh ch3 overrun keeps ovf[3]
        restart();
        evt_ready = 1'b0;
        wr(2'd3, 1'b1, 16'd1);
        wr(2'd0, 1'b1, 16'd1);
        while (ecnt < 8) tick();
        chk("clr_pre_ovf", 32'(ovf), 32'h9);
        wr(2'd0, 1'b0, 16'd1);
        while (ecnt < 11) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf_race", 32'(ovf), 32'h8);
        chk("clr_presented", 32'({evt_valid, evt_id}), 32'h4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf_all", 32'(ovf), 32'h0);

        // Asynchronous reset while presenting; nothing is replayed afterwards
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("arst_quiet", 32'(evt_valid), 32'd0);
        end
        chk("arst_ovf", 32'(ovf), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
